// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction field positions, opcodes and flag bit indices.
// Used by the decode stage, the register file and the ALU.
package cpu_pkg;

  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 10;
  localparam int unsigned RD_HI  = 9;
  localparam int unsigned RD_LO  = 7;
  localparam int unsigned RS1_HI = 6;
  localparam int unsigned RS1_LO = 4;
  localparam int unsigned RS2_HI = 3;
  localparam int unsigned RS2_LO = 1;
  localparam int unsigned IMM_HI = 6;
  localparam int unsigned IMM_LO = 0;

  localparam logic [5:0] OP_ADD  = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_MUL  = 6'b000011;
  localparam logic [5:0] OP_BIT  = 6'b000100;
  localparam logic [5:0] OP_AND  = 6'b000101;
  localparam logic [5:0] OP_OR   = 6'b000110;
  localparam logic [5:0] OP_XOR  = 6'b000111;
  localparam logic [5:0] OP_ROL  = 6'b001000;
  localparam logic [5:0] OP_SHL  = 6'b001001;
  localparam logic [5:0] OP_ROR  = 6'b001010;
  localparam logic [5:0] OP_SHR  = 6'b001011;
  localparam logic [5:0] OP_ADDI = 6'b100000;
  localparam logic [5:0] OP_SUBI = 6'b100001;
  localparam logic [5:0] OP_LDA  = 6'b100100;
  localparam logic [5:0] OP_STA  = 6'b100101;

  // Flag register layout is {Z,C,S,O}.
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_S = 1;
  localparam int unsigned FLAG_O = 0;

  typedef enum logic [1:0] {
    CLS_ILL = 2'd0,
    CLS_R   = 2'd1,
    CLS_I   = 2'd2
  } op_class_e;

  function automatic op_class_e op_class(input logic [5:0] opc);
    if (opc >= OP_ADD && opc <= OP_SHR)
      return CLS_R;
    if (opc == OP_ADDI || opc == OP_SUBI || opc == OP_LDA || opc == OP_STA)
      return CLS_I;
    return CLS_ILL;
  endfunction

  function automatic logic [15:0] sext7(input logic [6:0] imm);
    return {{9{imm[6]}}, imm};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Instruction-in / ALU-bundle-out handshake bus of the decode stage.
// master = decode stage side, slave = fetch/execute environment side.
interface decode_stage_if;
  logic [15:0] instr;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  mode;
  logic [15:0] operand1;
  logic [15:0] operand2;
  logic [3:0]  flags;
  logic [2:0]  rd;
  logic        wr_en;
  logic        illegal;

  modport master (
    input  instr, in_valid, out_ready,
    output in_ready, out_valid, mode, operand1, operand2, flags, rd, wr_en, illegal
  );

  modport slave (
    output instr, in_valid, out_ready,
    input  in_ready, out_valid, mode, operand1, operand2, flags, rd, wr_en, illegal
  );
endinterface

// File: rtl/regfile_8x16.sv
// 8x16 register file, R0 hard-wired to zero, two async read ports.
// With DECODE_BYPASS_EN defined, a same-cycle write is forwarded onto the read ports.
module regfile_8x16
  import cpu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [2:0]  i_waddr,
  input  logic [15:0] i_wdata,
  input  logic [2:0]  i_raddr_a,
  input  logic [2:0]  i_raddr_b,
  output logic [15:0] o_rdata_a,
  output logic [15:0] o_rdata_b
);

  logic [15:0] r_mem [0:7];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++)
        r_mem[i] <= '0;
    end else if (i_we && i_waddr != 3'd0) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata_a = (i_raddr_a == 3'd0) ? 16'h0000 : r_mem[i_raddr_a];
    o_rdata_b = (i_raddr_b == 3'd0) ? 16'h0000 : r_mem[i_raddr_b];
`ifdef DECODE_BYPASS_EN
    if (i_we && i_waddr != 3'd0 && i_waddr == i_raddr_a)
      o_rdata_a = i_wdata;
    if (i_we && i_waddr != 3'd0 && i_waddr == i_raddr_b)
      o_rdata_b = i_wdata;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field decode, register read, busy scoreboard, output skid register, flags.
// Optional DECODE_BYPASS_EN forwards same-cycle writebacks instead of stalling one cycle.
module decode_stage
  import cpu_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_instr,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [5:0]  o_mode,
  output logic [15:0] o_operand1,
  output logic [15:0] o_operand2,
  output logic [3:0]  o_flags,
  output logic [2:0]  o_rd,
  output logic        o_wr_en,
  output logic        o_illegal,
  input  logic        i_wb_valid,
  input  logic [2:0]  i_wb_rd,
  input  logic [15:0] i_wb_data,
  input  logic        i_flags_we,
  input  logic [3:0]  i_alu_flags,
  input  logic        i_flush
);

  logic [5:0]  w_opc;
  logic [2:0]  w_rd, w_rs1, w_rs2;
  logic [6:0]  w_imm;
  op_class_e   w_cls;
  logic        w_legal, w_wr_en, w_hazard, w_ready, w_accept;
  logic [2:0]  w_raddr_a;
  logic [15:0] w_rdata_a, w_rdata_b;
  logic [7:0]  w_busy_src, w_wb_mask, w_flush_mask, w_set_mask;
  logic        w_unused;

  logic        r_valid, r_illegal, r_wr_en;
  logic [5:0]  r_mode;
  logic [2:0]  r_rd;
  logic [15:0] r_operand1, r_operand2;
  logic [3:0]  r_flags;
  logic [7:0]  r_busy;

  assign w_opc    = i_instr[OPC_HI:OPC_LO];
  assign w_rd     = i_instr[RD_HI:RD_LO];
  assign w_rs1    = i_instr[RS1_HI:RS1_LO];
  assign w_rs2    = i_instr[RS2_HI:RS2_LO];
  assign w_imm    = i_instr[IMM_HI:IMM_LO];
  assign w_unused = i_instr[0];

  assign w_cls   = op_class(w_opc);
  assign w_legal = (w_cls != CLS_ILL);
  assign w_wr_en = w_legal && (w_opc != OP_STA);

  // I-ops read their own destination as operand1.
  assign w_raddr_a = (w_cls == CLS_I) ? w_rd : w_rs1;

  regfile_8x16 u_regfile (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_we      (i_wb_valid),
    .i_waddr   (i_wb_rd),
    .i_wdata   (i_wb_data),
    .i_raddr_a (w_raddr_a),
    .i_raddr_b (w_rs2),
    .o_rdata_a (w_rdata_a),
    .o_rdata_b (w_rdata_b)
  );

  assign w_wb_mask    = i_wb_valid ? (8'b1 << i_wb_rd) : 8'h00;
  assign w_flush_mask = (i_flush && r_valid && r_wr_en) ? (8'b1 << r_rd) : 8'h00;
  assign w_set_mask   = (w_accept && w_wr_en && w_rd != 3'd0) ? (8'b1 << w_rd) : 8'h00;

`ifdef DECODE_BYPASS_EN
  assign w_busy_src = r_busy & ~w_wb_mask;
`else
  assign w_busy_src = r_busy;
`endif

  always_comb begin
    w_hazard = 1'b0;
    case (w_cls)
      CLS_R:   w_hazard = w_busy_src[w_rs1] || w_busy_src[w_rs2];
      CLS_I:   w_hazard = w_busy_src[w_rd];
      default: w_hazard = 1'b0;
    endcase
  end

  assign w_ready  = !w_hazard && (!r_valid || i_ready) && !i_flush;
  assign w_accept = i_valid && w_ready;

  // Set is applied last so a new claim beats a same-cycle writeback clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_busy <= 8'h00;
    else
      r_busy <= (r_busy & ~(w_wb_mask | w_flush_mask)) | w_set_mask;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid    <= 1'b0;
      r_illegal  <= 1'b0;
      r_wr_en    <= 1'b0;
      r_mode     <= '0;
      r_rd       <= '0;
      r_operand1 <= '0;
      r_operand2 <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_illegal  <= !w_legal;
      r_wr_en    <= w_wr_en;
      r_mode     <= w_legal ? w_opc : 6'd0;
      r_rd       <= w_rd;
      r_operand1 <= w_legal ? w_rdata_a : 16'h0000;
      r_operand2 <= (w_cls == CLS_R) ? w_rdata_b :
                    (w_cls == CLS_I) ? sext7(w_imm) : 16'h0000;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_flags <= FLAGS_RST;
    else if (i_flags_we)
      r_flags <= i_alu_flags;
  end

  assign o_ready    = w_ready;
  assign o_valid    = r_valid;
  assign o_illegal  = r_illegal;
  assign o_wr_en    = r_wr_en;
  assign o_mode     = r_mode;
  assign o_rd       = r_rd;
  assign o_operand1 = r_operand1;
  assign o_operand2 = r_operand2;
  assign o_flags    = r_flags;

endmodule
